pending_priority_encoder: RTL

Parametrised, registered successor to the combinational 8-bit priority encoder. Latches request pulses from WIDTH sources into a sticky pending register, applies a per-source mask, and presents one winning index at a time over a valid/ready handshake. Supports fixed lowest-index-first priority or round-robin priority. Sits between event sources (interrupt lines, channel done flags) and a single consumer that services one index per handshake.

---
 rtl/pending_priority_encoder.sv | 103 ++++++++++
 1 files changed

// File: rtl/pending_priority_encoder.sv
// Sticky pending-request register feeding a fixed/round-robin priority encoder.
// One winning index at a time is presented over a valid/ready handshake.
module pending_priority_encoder #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] req_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic             rr_mode_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [WIDTH-1:0] pending_o
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, last_q;
  logic             valid_q;

  logic [WIDTH-1:0] elig, clr;
  logic [IDX_W-1:0] win_fixed, win_rr;
  logic             found_fixed, found_rr;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= WIDTH) s = s - WIDTH;
    return IDX_W'(s);
  endfunction

  assign elig = pending_q & ~mask_i;

  // A new request in the same cycle as its own clear keeps the bit set.
  always_comb begin
    clr = '0;
    if (valid_q && out_ready_i) clr[idx_q] = 1'b1;
    pending_d = (pending_q & ~clr) | req_i;
  end

  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    win_fixed   = '0;
    found_fixed = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found_fixed && elig[i]) begin
        win_fixed   = IDX_W'(i);
        found_fixed = 1'b1;
      end
    end
  end

  // Search starts just above the last grant, so the last grant ranks lowest.
  always_comb begin
    win_rr   = '0;
    found_rr = 1'b0;
    for (int off = 1; off <= WIDTH; off++) begin
      if (!found_rr && elig[wrap_idx(last_q, off)]) begin
        win_rr   = wrap_idx(last_q, off);
        found_rr = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      last_q    <= IDX_W'(WIDTH - 1);
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (elig != '0) begin
            idx_q   <= rr_mode_i ? win_rr : win_fixed;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            last_q  <= idx_q;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = valid_q;
  assign out_idx_o   = idx_q;
  assign pending_o   = pending_q;

endmodule
